// File: rtl/audio_adc_deserializer.sv
// WM8731 ADC serial stream to parallel left/right sample pairs.
// Pins are synchronized into iCLK; one pair per LRCK frame, single-entry output.
module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 16,
    parameter bit I2S_MODE   = 1'b1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iAUD_BCLK,
    input  logic                  iAUD_ADCLRCK,
    input  logic                  iAUD_ADCDAT,
    output logic [DATA_WIDTH-1:0] oLEFT,
    output logic [DATA_WIDTH-1:0] oRIGHT,
    output logic                  oVALID,
    input  logic                  iREADY,
    output logic                  oOVERRUN,
    output logic                  oFRAME_ERR
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        DELAY,
        SHIFT,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [2:0] bclk_q;
    logic [2:0] lrck_q;
    logic [1:0] dat_q;

    logic bclk_rise;
    logic lrck_edge;
    logic left_start;
    logic bit_in;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-2:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] left_hold;
    logic                  chan;
    logic                  pair_bad;

    logic start;
    logic take_bit;
    logic short_word;
    logic word_done;
    logic new_left;
    logic pair_complete;

    // Pin pipeline is left unreset so history stays true to the pins
    // and a reset cannot fabricate an LRCK edge.
    always_ff @(posedge iCLK) begin
        bclk_q <= {bclk_q[1:0], iAUD_BCLK};
        lrck_q <= {lrck_q[1:0], iAUD_ADCLRCK};
        dat_q  <= {dat_q[0], iAUD_ADCDAT};
    end

    assign bclk_rise  = bclk_q[1] & ~bclk_q[2];
    assign lrck_edge  = lrck_q[1] ^ lrck_q[2];
    assign left_start = lrck_edge && (lrck_q[1] != I2S_MODE);
    assign bit_in     = dat_q[1];
    assign shifted    = {shreg, bit_in};

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            WAIT_SYNC: begin
                if (left_start) begin
                    state_n = (I2S_MODE && !bclk_rise) ? DELAY : SHIFT;
                end
            end
            DELAY, SHIFT, HOLD: begin
                if (lrck_edge) begin
                    state_n = (I2S_MODE && !bclk_rise) ? DELAY : SHIFT;
                end else if (state == DELAY && bclk_rise) begin
                    state_n = SHIFT;
                end else if (word_done) begin
                    state_n = HOLD;
                end
            end
            default: state_n = WAIT_SYNC;
        endcase
    end

    // A bit coinciding with an LRCK edge belongs to the new channel.
    always_comb begin
        start      = (state == WAIT_SYNC) ? left_start : lrck_edge;
        take_bit   = bclk_rise &&
                     ((state == SHIFT && !lrck_edge) || (start && !I2S_MODE));
        short_word = lrck_edge && (state == SHIFT) &&
                     (count < CW'(DATA_WIDTH));
        word_done  = take_bit && !start &&
                     (count == CW'(DATA_WIDTH - 1));
        new_left   = (state == WAIT_SYNC) || chan;
    end

    assign pair_complete = word_done && chan && !pair_bad;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count     <= '0;
            shreg     <= '0;
            chan      <= 1'b0;
            left_hold <= '0;
            pair_bad  <= 1'b0;
        end else if (start) begin
            chan  <= !new_left;
            count <= take_bit ? CW'(1) : '0;
            shreg <= take_bit ? (DATA_WIDTH-1)'(bit_in) : '0;
            if (new_left) begin
                pair_bad <= 1'b0;
            end else if (short_word) begin
                pair_bad <= 1'b1;
            end
        end else if (take_bit) begin
            shreg <= shifted[DATA_WIDTH-2:0];
            count <= count + CW'(1);
            if (word_done && !chan) begin
                left_hold <= shifted;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oLEFT      <= '0;
            oRIGHT     <= '0;
            oVALID     <= 1'b0;
            oOVERRUN   <= 1'b0;
            oFRAME_ERR <= 1'b0;
        end else begin
            oFRAME_ERR <= short_word;
            if (pair_complete) begin
                oLEFT  <= left_hold;
                oRIGHT <= shifted;
                oVALID <= 1'b1;
                if (oVALID && !iREADY) begin
                    oOVERRUN <= 1'b1;
                end
            end else if (oVALID && iREADY) begin
                oVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_adc_deserializer.sv
// Directed bench for audio_adc_deserializer, I2S and left-justified builds.
// Codec pins are driven from an asynchronous bit-clock timebase.
module tb_audio_adc_deserializer;

    localparam int HALF_CLK  = 10;
    localparam int HALF_BCLK = 163;

    logic iCLK = 1'b0;
    logic iRST = 1'b0;
    logic bclk = 1'b0;
    logic lrck = 1'b1;
    logic dat  = 1'b0;
    logic rdy  = 1'b1;

    logic [15:0] i2s_left, i2s_right, lj_left, lj_right;
    logic i2s_valid, i2s_ovr, i2s_ferr;
    logic lj_valid, lj_ovr, lj_ferr;

    int n_chk = 0;
    int n_err = 0;
    bit sel = 1'b0;
    bit mode_i2s = 1'b1;
    longint lsb_t = 0;

    int n_acc = 0;
    int n_ferr = 0;
    longint vrise_t = 0;
    logic [15:0] acc_l = '0;
    logic [15:0] acc_r = '0;
    logic pv = 1'b0;

    always #HALF_CLK iCLK = ~iCLK;

    audio_adc_deserializer #(.DATA_WIDTH(16), .I2S_MODE(1'b1)) dut_i2s (
        .iCLK(iCLK), .iRST(iRST), .iAUD_BCLK(bclk),
        .iAUD_ADCLRCK(lrck), .iAUD_ADCDAT(dat),
        .oLEFT(i2s_left), .oRIGHT(i2s_right), .oVALID(i2s_valid),
        .iREADY(rdy), .oOVERRUN(i2s_ovr), .oFRAME_ERR(i2s_ferr)
    );

    audio_adc_deserializer #(.DATA_WIDTH(16), .I2S_MODE(1'b0)) dut_lj (
        .iCLK(iCLK), .iRST(iRST), .iAUD_BCLK(bclk),
        .iAUD_ADCLRCK(lrck), .iAUD_ADCDAT(dat),
        .oLEFT(lj_left), .oRIGHT(lj_right), .oVALID(lj_valid),
        .iREADY(rdy), .oOVERRUN(lj_ovr), .oFRAME_ERR(lj_ferr)
    );

    logic mv, mferr;
    logic [15:0] ml, mr;
    always_comb begin
        mv    = sel ? lj_valid : i2s_valid;
        mferr = sel ? lj_ferr : i2s_ferr;
        ml    = sel ? lj_left : i2s_left;
        mr    = sel ? lj_right : i2s_right;
    end

    always @(posedge iCLK) begin
        #1;
        if (mv && !pv) vrise_t = $time;
        pv = mv;
        if (mv && rdy) begin
            n_acc = n_acc + 1;
            acc_l = ml;
            acc_r = mr;
        end
        if (mferr) n_ferr = n_ferr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_chan(input logic lvl, input logic [15:0] w,
                             input int nbits, input int rst_bit,
                             input bit mark);
        int dly;
        int total;
        dly = mode_i2s ? 1 : 0;
        total = (nbits < 16) ? nbits + dly : 32;
        for (int i = 0; i < total; i++) begin
            if (i == 0) lrck = lvl;
            if (i < dly) dat = 1'b1;
            else if (i - dly < nbits) dat = w[15 - (i - dly)];
            else dat = 1'b1;
            if (i == rst_bit) begin
                @(negedge iCLK) iRST = 1'b1;
                @(negedge iCLK) iRST = 1'b0;
            end
            #HALF_BCLK;
            bclk = 1'b1;
            if (mark && (i - dly == 15)) lsb_t = $time;
            #HALF_BCLK;
            bclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        logic ll;
        ll = mode_i2s ? 1'b0 : 1'b1;
        send_chan(ll, l, 16, -1, 1'b0);
        send_chan(!ll, r, 16, -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1);
    end

    initial begin
        int a0;
        int f0;
        longint d;

        // reset with bit clock running
        @(negedge iCLK);
        iRST = 1'b1;
        repeat (3) @(negedge iCLK) bclk = ~bclk;
        chk("rst_valid", i2s_valid, 0);
        chk("rst_left", i2s_left, 0);
        chk("rst_right", i2s_right, 0);
        chk("rst_ovr", i2s_ovr, 0);
        chk("rst_ferr", i2s_ferr, 0);
        chk("rst_lj_valid", lj_valid, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        bclk = 1'b0;

        // I2S capture, stream starts mid right channel
        a0 = n_acc;
        send_chan(1'b1, 16'hAAAA, 16, -1, 1'b0);
        chk("i2s_no_early", n_acc - a0, 0);
        send_chan(1'b0, 16'h8001, 16, -1, 1'b0);
        send_chan(1'b1, 16'h7FFE, 16, -1, 1'b1);
        chk("i2s_count", n_acc - a0, 1);
        chk("i2s_left", acc_l, 16'h8001);
        chk("i2s_right", acc_r, 16'h7FFE);
        d = vrise_t - lsb_t;
        chk("i2s_latency", (d > 20 && d <= 81), 1);

        // backpressure over two frames
        @(negedge iCLK) rdy = 1'b0;
        send_frame(16'h0001, 16'h0002);
        chk("bp_valid1", i2s_valid, 1);
        chk("bp_ovr1", i2s_ovr, 0);
        send_frame(16'h0003, 16'h0004);
        chk("bp_valid2", i2s_valid, 1);
        chk("bp_left", i2s_left, 16'h0003);
        chk("bp_right", i2s_right, 16'h0004);
        chk("bp_ovr2", i2s_ovr, 1);
        @(negedge iCLK) rdy = 1'b1;
        @(negedge iCLK) rdy = 1'b0;
        chk("bp_drain", i2s_valid, 0);
        chk("bp_ovr_sticky", i2s_ovr, 1);
        @(negedge iCLK) rdy = 1'b1;

        // short left word poisons the pair
        a0 = n_acc;
        f0 = n_ferr;
        send_chan(1'b0, 16'h5555, 10, -1, 1'b0);
        send_chan(1'b1, 16'h1111, 16, -1, 1'b0);
        chk("short_ferr", n_ferr - f0, 1);
        chk("short_noout", n_acc - a0, 0);
        send_frame(16'h2222, 16'h3333);
        chk("short_recov", n_acc - a0, 1);
        chk("short_left", acc_l, 16'h2222);
        chk("short_right", acc_r, 16'h3333);
        chk("short_ferr_once", n_ferr - f0, 1);

        // reset during right-channel bit 7
        a0 = n_acc;
        send_chan(1'b0, 16'h4444, 16, -1, 1'b0);
        send_chan(1'b1, 16'h5A5A, 16, 8, 1'b0);
        chk("mrst_noout", n_acc - a0, 0);
        chk("mrst_valid", i2s_valid, 0);
        chk("mrst_left", i2s_left, 0);
        chk("mrst_right", i2s_right, 0);
        chk("mrst_ovr", i2s_ovr, 0);
        send_frame(16'h6666, 16'h7777);
        chk("mrst_count", n_acc - a0, 1);
        chk("mrst_left2", acc_l, 16'h6666);
        chk("mrst_right2", acc_r, 16'h7777);

        // left-justified build
        @(negedge iCLK);
        sel = 1'b1;
        mode_i2s = 1'b0;
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        a0 = n_acc;
        send_chan(1'b0, 16'hBBBB, 16, -1, 1'b0);
        chk("lj_no_early", n_acc - a0, 0);
        send_frame(16'h1234, 16'hFEDC);
        chk("lj_count", n_acc - a0, 1);
        chk("lj_left", acc_l, 16'h1234);
        chk("lj_right", acc_r, 16'hFEDC);
        send_frame(16'h8000, 16'h0001);
        chk("lj_count2", n_acc - a0, 2);
        chk("lj_left2", acc_l, 16'h8000);
        chk("lj_right2", acc_r, 16'h0001);

        repeat (4) @(negedge iCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
